// File: rtl/cs_feeder.sv
// rtl/cs_feeder.sv - sample FIFO and window sequencer that feeds an external averaging core
module cs_feeder #(
  parameter int DEPTH = 16,
  parameter int WIN   = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  input  logic                    start,
  input  logic                    stop,
  output logic [7:0]              x,
  output logic                    cs_rst,
  input  logic [9:0]              y_in,
  output logic [9:0]              y_out,
  output logic                    y_valid,
  output logic [3:0]              win_idx,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [3:0]    WIN_LAST   = 4'(WIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [3:0]    fill_cnt;
  logic [3:0]    slot;
  logic          push;
  logic          emit;
  logic          pop;
  logic          go;

  // Pointers carry one extra bit so a full FIFO (level == DEPTH) differs from an empty one.
  assign level   = wr_ptr - rd_ptr;
  assign s_ready = (level < FULL_LEVEL);
  assign push    = s_valid && s_ready;

  // stop wins over start; start only matters in IDLE, stop only outside IDLE.
  assign go   = (state == IDLE) && start && !stop;
  assign emit = (state != IDLE) && !stop;
  assign pop  = emit && (level != '0);

  // Sample storage; contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_data;
    end
  end

  // Write side of the FIFO; a push into a full FIFO is simply not accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + LW'(1);
    end
  end

  // Sequencer: pops one sample per edge while active, tracks the window slot and captures results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      x         <= '0;
      cs_rst    <= 1'b1;
      y_out     <= '0;
      y_valid   <= 1'b0;
      win_idx   <= '0;
      underflow <= 1'b0;
      fill_cnt  <= '0;
      slot      <= '0;
    end else begin
      y_valid <= 1'b0;
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      case (state)
        IDLE: begin
          x       <= '0;
          cs_rst  <= 1'b1;
          win_idx <= '0;
          if (go) begin
            state     <= FILL;
            cs_rst    <= 1'b0;
            underflow <= 1'b0;
            fill_cnt  <= '0;
            slot      <= '0;
          end
        end
        FILL, STREAM: begin
          if (stop) begin
            // Leave FIFO and y_out untouched so streaming can resume later.
            state   <= IDLE;
            cs_rst  <= 1'b1;
            x       <= '0;
            win_idx <= '0;
          end else begin
            // An empty FIFO repeats the last sample but the window still advances.
            if (pop) begin
              x <= mem[rd_ptr[AW-1:0]];
            end else begin
              underflow <= 1'b1;
            end
            win_idx <= slot;
            slot    <= (slot == WIN_LAST) ? 4'd0 : slot + 4'd1;
            if (state == FILL) begin
              fill_cnt <= fill_cnt + 4'd1;
              if (fill_cnt == WIN_LAST) begin
                state <= STREAM;
              end
            end else begin
              // Every STREAM edge follows an emit edge, so the core output is valid here.
              y_out   <= y_in;
              y_valid <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cs_feeder.md
CS_FEEDER -- requirements
Module: cs_feeder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning sample FIFO entries (power of 2).
REQ-002 The module SHALL have parameter WIN, default 9, meaning samples per averaging window.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port s_valid  input  1  host sample valid.
REQ-006 The module SHALL have port s_data  input  8  host sample, unsigned.
REQ-007 The module SHALL have port s_ready  output  1  FIFO can accept; high when level < DEPTH.
REQ-008 The module SHALL have port start  input  1  one-cycle pulse; begin streaming.
REQ-009 The module SHALL have port stop  input  1  one-cycle pulse; end streaming.
REQ-010 The module SHALL have port x  output  8  sample to the averaging core, one per clk.
REQ-011 The module SHALL have port cs_rst  output  1  reset to the averaging core.
REQ-012 The module SHALL have port y_in  input  10  filtered result from the averaging core.
REQ-013 The module SHALL have port y_out  output  10  captured result.
REQ-014 The module SHALL have port y_valid  output  1  one-cycle pulse; y_out updated.
REQ-015 The module SHALL have port win_idx  output  4  slot (0..WIN-1) of the last emitted sample.
REQ-016 The module SHALL have port level  output  5  FIFO occupancy, 0..DEPTH.
REQ-017 The module SHALL have port underflow  output  1  sticky; FIFO was empty at an emit edge.

Function
REQ-018 The FSM SHALL have states IDLE, FILL, STREAM; the reset state is IDLE.
REQ-019 A FIFO write SHALL occur on a clk edge with s_valid && s_ready; an s_valid with level == DEPTH SHALL be dropped without corrupting contents.
REQ-020 IDLE: cs_rst = 1, x = 0, no FIFO pops, win_idx = 0, y_valid = 0.
REQ-021 IDLE -> FILL on start; underflow SHALL clear on the same edge; fill_cnt SHALL clear on the same edge.
REQ-022 In FILL and STREAM, cs_rst = 0, and on every clk edge the module SHALL pop one FIFO entry into x (registered, valid from the edge).
REQ-023 If the FIFO is empty at an emit edge, x SHALL hold its previous value, underflow SHALL set, and window counting SHALL still advance.
REQ-024 win_idx SHALL advance on each emit edge and wrap WIN-1 -> 0; the first sample after start SHALL have win_idx = 0.
REQ-025 FILL -> STREAM on the edge emitting the WIN-th sample (fill_cnt == WIN-1).
REQ-026 In STREAM, on the edge following each emit edge, y_out <= y_in and y_valid = 1 for one cycle; the first y_valid SHALL come one cycle after the WIN-th sample is emitted.
REQ-027 A stop in FILL or STREAM SHALL return the FSM to IDLE on that edge; the FIFO contents SHALL be retained; y_out SHALL hold its value.
REQ-028 start in FILL/STREAM SHALL be ignored; stop in IDLE SHALL be ignored; simultaneous start and stop SHALL be resolved as stop.
REQ-029 A simultaneous push and pop on one edge SHALL leave level unchanged; a push and pop on an empty FIFO SHALL emit the old x (underflow) and store the new sample.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; level SHALL be computed with one extra bit so that full and empty are distinct.

Reset
REQ-031 When reset is asserted, the module SHALL asynchronously force: state = IDLE, FIFO empty (level = 0), s_ready = 1, x = 0, cs_rst = 1, y_out = 0, y_valid = 0, win_idx = 0, underflow = 0.
REQ-032 A reset mid-stream SHALL discard all FIFO contents, and streaming SHALL require a new start.

Verification
REQ-033 The bench SHALL cover: push 0,10,20,...,80 then start -> x = 0..80 on 9 consecutive edges, win_idx 0..8, cs_rst falls on the start edge, first y_valid 1 cycle after x = 80.
REQ-034 The bench SHALL cover: push 17 samples with the FIFO not drained -> s_ready low at level 16, 17th dropped, level = 16.
REQ-035 The bench SHALL cover: push 5 samples, start -> after 5 emits, x repeats the 5th value, underflow = 1, win_idx keeps advancing; a new start clears underflow.
REQ-036 The bench SHALL cover: stream 12 samples, stop at edge 12 -> state IDLE, cs_rst = 1, x = 0, y_out holds last capture, remaining FIFO entries kept.
REQ-037 The bench SHALL cover: assert reset mid-STREAM with level = 7 -> level = 0, y_out = 0, underflow = 0 immediately, with no clock needed.
REQ-038 The bench SHALL cover: start and stop asserted together in IDLE, then in STREAM -> stays IDLE; goes IDLE.
